// File: rtl/key_step_conditioner_pkg.sv
// Shared types and constants for the key step conditioner and its detector.
package key_cond_pkg;

  typedef enum logic [1:0] {
    ST_UP        = 2'b00,
    ST_DOWN_PEND = 2'b01,
    ST_DOWN      = 2'b10,
    ST_UP_PEND   = 2'b11
  } key_state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int unsigned SIM_DEBOUNCE            = 4;

endpackage

// File: rtl/key_step_conditioner_if.sv
// Conditioned step/sample bundle delivered to the sequence detector.
interface key_step_conditioner_if;

  logic       step;
  logic       w_sampled;
  logic       key_level;
  logic [7:0] press_count;

  modport master (output step, output w_sampled, output key_level, output press_count);
  modport slave  (input  step, input  w_sampled, input  key_level, input  press_count);

endinterface

// File: rtl/key_step_conditioner_sync2.sv
// Two-flop synchronizer with a configurable reset level.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_step_conditioner.sv
// Debounces the active-low step key into a one-cycle step pulse and captures w alongside it.
module key_step_conditioner
  import key_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    key_n,
  input  logic                    w_raw,
  key_step_conditioner_if.master  det
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic       key_sync;
  logic       w_sync;
  logic       pressed;
  key_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic       step_set;

  // Key path idles released (1) so reset never looks like a press.
  sync2 #(.RESET_VAL(1'b1)) u_sync_key (
    .clock (clock),
    .reset (reset),
    .d     (key_n),
    .q     (key_sync)
  );

  sync2 #(.RESET_VAL(1'b0)) u_sync_w (
    .clock (clock),
    .reset (reset),
    .d     (w_raw),
    .q     (w_sync)
  );

  assign pressed = ~key_sync;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    step_set  = 1'b0;
    case (state)
      ST_UP: begin
        if (pressed) begin
          state_nxt = ST_DOWN_PEND;
          cnt_nxt   = '0;
        end
      end
      ST_DOWN_PEND: begin
        if (!pressed) begin
          state_nxt = ST_UP;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_DOWN;
          step_set  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_DOWN: begin
        if (!pressed) begin
          state_nxt = ST_UP_PEND;
          cnt_nxt   = '0;
        end
      end
      ST_UP_PEND: begin
        if (pressed) begin
          state_nxt = ST_DOWN;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_UP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_UP;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_UP;
      cnt             <= '0;
      det.step        <= 1'b0;
      det.w_sampled   <= 1'b0;
      det.press_count <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      det.step <= step_set;
      if (step_set) begin
        det.w_sampled   <= w_sync;
        det.press_count <= det.press_count + 8'd1;
      end
    end
  end

  // Debounced level is high exactly in DOWN and UP_PEND.
  assign det.key_level = (state == ST_DOWN) || (state == ST_UP_PEND);

endmodule

// File: tb/tb_key_step_conditioner.sv
// Directed bench for key_step_conditioner with a 4-cycle debounce window.
module tb_key_step_conditioner;
  import key_cond_pkg::*;

  logic clock;
  logic reset;
  logic key_n;
  logic w_raw;

  int compared;
  int mismatched;

  key_step_conditioner_if dif ();

  key_step_conditioner #(
    .DEBOUNCE_CYCLES (SIM_DEBOUNCE)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .key_n  (key_n),
    .w_raw  (w_raw),
    .det    (dif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic b;
    int   steps_seen;
    compared   = 0;
    mismatched = 0;
    reset = 1'b1;
    key_n = 1'b1;
    w_raw = 1'b0;

    // Reset defaults
    tick();
    tick();
    check("rst_step",  {31'd0, dif.step},      32'd0);
    check("rst_level", {31'd0, dif.key_level}, 32'd0);
    check("rst_w",     {31'd0, dif.w_sampled}, 32'd0);
    check("rst_count", {24'd0, dif.press_count}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Short glitch: 3 sampled low cycles
    key_n = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    key_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("glitch_step",  {31'd0, dif.step},      32'd0);
      check("glitch_level", {31'd0, dif.key_level}, 32'd0);
    end
    check("glitch_count", {24'd0, dif.press_count}, 32'd0);

    // Clean press: step after edge t0+6 only
    key_n = 1'b0;
    w_raw = 1'b1;
    steps_seen = 0;
    for (int k = 0; k <= 8; k++) begin
      tick();
      if (dif.step) steps_seen++;
      check("press_step",  {31'd0, dif.step},      (k == 6) ? 32'd1 : 32'd0);
      check("press_level", {31'd0, dif.key_level}, (k >= 6) ? 32'd1 : 32'd0);
      if (k == 6) begin
        check("press_w",     {31'd0, dif.w_sampled},   32'd1);
        check("press_count", {24'd0, dif.press_count}, 32'd1);
      end
    end
    check("press_single", steps_seen, 32'd1);

    // Release bounce while pressed
    key_n = 1'b1; tick();
    key_n = 1'b0; tick();
    key_n = 1'b1; tick();
    key_n = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      check("bounce_step",  {31'd0, dif.step},      32'd0);
      check("bounce_level", {31'd0, dif.key_level}, 32'd1);
    end
    check("bounce_count", {24'd0, dif.press_count}, 32'd1);

    key_n = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check("release_level", {31'd0, dif.key_level}, 32'd0);

    // Mid-debounce reset with key held
    key_n = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b1;
    tick();
    check("mrst_step0", {31'd0, dif.step}, 32'd0);
    tick();
    check("mrst_step1", {31'd0, dif.step}, 32'd0);
    check("mrst_count", {24'd0, dif.press_count}, 32'd0);
    reset = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      tick();
      check("mrst_post_step", {31'd0, dif.step}, (k == 6) ? 32'd1 : 32'd0);
    end
    check("mrst_post_count", {24'd0, dif.press_count}, 32'd1);
    check("mrst_post_level", {31'd0, dif.key_level},   32'd1);
    key_n = 1'b1;
    for (int k = 0; k < 10; k++) tick();

    // Wrap: 256 presses from a fresh reset, w changing around the sample point
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 256; i++) begin
      b = (i % 3 == 0);
      w_raw = ~b;
      key_n = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      w_raw = b;
      tick();
      w_raw = ~b;
      tick();
      check("wrap_step_early", {31'd0, dif.step}, 32'd0);
      tick();
      check("wrap_step",  {31'd0, dif.step},      32'd1);
      check("wrap_w",     {31'd0, dif.w_sampled}, {31'd0, b});
      check("wrap_count", {24'd0, dif.press_count}, (i + 1) % 256);
      key_n = 1'b1;
      tick();
      check("wrap_step_late", {31'd0, dif.step}, 32'd0);
      for (int k = 0; k < 8; k++) tick();
      check("wrap_w_hold", {31'd0, dif.w_sampled}, {31'd0, b});
    end
    check("wrap_final_count", {24'd0, dif.press_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/key_step_conditioner.md
# key_step_conditioner

Input-conditioning stage that sits directly upstream of the four-in-a-row sequence detector. It synchronizes and debounces the raw active-low step pushbutton and emits a single-cycle `step` pulse per physical press. It also delivers a `w` sample that is captured on the same cycle and held stable between steps. The detector runs on the system clock, uses `step` as its state-register enable, and uses `w_sampled` as its `w` input, so it no longer uses the button as a clock.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz). Must be ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: debounce counter width.

Ports:
- `clock` — input, 1 bit: system clock. All logic is on the rising edge.
- `reset` — input, 1 bit: synchronous, active-high.
- `key_n` — input, 1 bit: raw pushbutton, asynchronous. 0 means pressed.
- `w_raw` — input, 1 bit: raw slide-switch data, asynchronous.
- `step` — output, 1 bit: one-cycle pulse per accepted press.
- `w_sampled` — output, 1 bit: synchronized `w`, captured on the cycle `step` rises and held until the next step.
- `key_level` — output, 1 bit: debounced button state. 1 means pressed.
- `press_count` — output, 8 bits: number of accepted presses, wraps modulo 256.

## Operation
- **Synchronizers:** two-flop synchronizers on both raw inputs.
  - `key_n` path resets to 1 (released), producing `key_sync`.
  - `w_raw` path resets to 0, producing `w_sync`.
- **Debounce FSM:** four states, `cnt` of width `CNT_W`.
  - **UP:** debounced released. If `key_sync`=0 (pressed): go to DOWN_PEND, `cnt`←0.
  - **DOWN_PEND:**
    - If released: return to UP, with no step.
    - Else if `cnt`==`DEBOUNCE_CYCLES`-1: go to DOWN, and `step`←1 at the same edge.
    - Else `cnt`++.
  - **DOWN:** debounced pressed. If released: go to UP_PEND, `cnt`←0.
  - **UP_PEND:**
    - If pressed: return to DOWN, with no new step.
    - Else if `cnt`==`DEBOUNCE_CYCLES`-1: go to UP.
    - Else `cnt`++.
- **Outputs:**
  - `step` is registered and high for exactly one cycle per UP→…→DOWN acceptance. It is otherwise 0.
  - `key_level` = 1 in DOWN and UP_PEND; 0 in UP and DOWN_PEND. It is decoded from the state register.
  - `w_sampled` ← `w_sync` at the edge that sets `step`; otherwise it holds.
  - `press_count` increments at the edge that sets `step`; 255→0 wraps silently.
- **Reset:** state UP, `cnt`=0, `step`=0, `w_sampled`=0, `press_count`=0, synchronizers as above.
  - Reset mid-DOWN_PEND aborts the press with no step.
  - A key held across reset release is treated as a fresh press: one step after the full debounce.
- **Bounces and glitches:**
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles after synchronization produces no step.
  - Release bounce (UP_PEND→DOWN) never produces a step.

## Timing
- Edge t0 is the first edge at which `key_n`=0 is sampled.
  - `key_sync`=0 after t0+1.
  - FSM enters DOWN_PEND at t0+2.
  - `step` is high in the cycle following edge t0+2+`DEBOUNCE_CYCLES`.
- Total press-to-step latency: `DEBOUNCE_CYCLES`+3 edges, counting t0.
- `w_sampled` reflects `w_raw` as it was sampled 2 edges before the step edge. It is valid in the same cycle `step` is high.
- Minimum spacing between two steps: 2·`DEBOUNCE_CYCLES`+2 cycles (full release debounce, then full press debounce).
- No combinational path from any input to any output.

## Structure
- Shared package `key_cond_pkg`:
  - 2-bit state encoding: UP=00, DOWN_PEND=01, DOWN=10, UP_PEND=11.
  - `DEBOUNCE_CYCLES` default constant.
  - Simulation value `SIM_DEBOUNCE`=4.
- One sub-module `sync2`: a parameterized two-flop synchronizer with a reset-value parameter, instantiated twice.
- Top level: FSM, counter, and output registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Reset defaults:** assert `reset` for 2 cycles with `key_n`=1 → `step`=0, `key_level`=0, `w_sampled`=0, `press_count`=0.
- **Clean press:** `w_raw`=1, drive `key_n`=0 at t0 and hold → `step` high for exactly 1 cycle after edge t0+6, `w_sampled`=1, `press_count`=1, `key_level`=1 from that cycle.
- **Short glitch:** `key_n`=0 for 3 cycles, then 1 → no step, `press_count` stays 0, `key_level` stays 0.
- **Release bounce:** after an accepted press, toggle `key_n` 1,0,1,0 one cycle each, then hold 0 → no second step, `key_level` remains 1.
- **Mid-debounce reset:** `reset` pulsed while in DOWN_PEND, key kept held → no step during reset; one step 7 edges after reset deassertion; `press_count`=1.
- **Wrap and hold:** 256 clean presses, with `w_raw` toggled between presses → `press_count` returns to 0, and each `w_sampled` equals `w_raw` from 2 edges before its step.
